// File: rtl/spell_mem_arbiter.sv
// spell_mem_arbiter: round-robin cpu/debug access to spell_mem with mandatory release cycle and stall timeout
module spell_mem_arbiter #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_req,
  input  logic       cpu_type_data,
  input  logic [7:0] cpu_addr,
  input  logic       cpu_write,
  input  logic [7:0] cpu_wdata,
  input  logic       dbg_req,
  input  logic       dbg_type_data,
  input  logic [7:0] dbg_addr,
  input  logic       dbg_write,
  input  logic [7:0] dbg_wdata,
  output logic       cpu_done,
  output logic       dbg_done,
  output logic       cpu_err,
  output logic       dbg_err,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       owner,
  output logic       mem_select,
  output logic       mem_type_data,
  output logic       mem_write,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data_in,
  input  logic [7:0] mem_data_out,
  input  logic       mem_data_ready
);
  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;
  state_t state, state_d;
  logic last_owner, pick_dbg, timeout, finish;
  logic [7:0] cnt;
  always_comb begin
    pick_dbg = dbg_req & (~cpu_req | ~last_owner);
    timeout = (TIMEOUT_CYCLES != 8'd0) && (cnt == TIMEOUT_CYCLES - 8'd1);
    finish = (state == ACCESS) && (mem_data_ready || timeout);
    state_d = state == IDLE ? ((cpu_req | dbg_req) ? ACCESS : IDLE) :
              state == ACCESS ? (finish ? RELEASE : ACCESS) : IDLE;
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      {cpu_done, dbg_done, cpu_err, dbg_err, busy, owner} <= '0;
      {mem_select, mem_type_data, mem_write, mem_addr, mem_data_in} <= '0;
      rdata <= '0;
      cnt <= '0;
      last_owner <= 1'b1;
    end else begin
      {cpu_done, dbg_done, cpu_err, dbg_err} <= '0;
      busy <= state_d != IDLE;
      if (state == IDLE && (cpu_req | dbg_req)) begin
        owner <= pick_dbg;
        last_owner <= pick_dbg;
        mem_select <= 1'b1;
        mem_type_data <= pick_dbg ? dbg_type_data : cpu_type_data;
        mem_addr <= pick_dbg ? dbg_addr : cpu_addr;
        mem_write <= pick_dbg ? dbg_write : cpu_write;
        mem_data_in <= pick_dbg ? dbg_wdata : cpu_wdata;
        cnt <= '0;
      end else if (finish) begin
        mem_select <= 1'b0;
        mem_write <= 1'b0;
        rdata <= mem_data_ready ? mem_data_out : 8'h00;
        cpu_done <= ~owner;
        dbg_done <= owner;
        cpu_err <= ~owner & ~mem_data_ready;
        dbg_err <= owner & ~mem_data_ready;
      end else if (state == ACCESS) begin
        cnt <= (cnt == 8'hff) ? cnt : cnt + 8'd1;
      end
    end
  end
endmodule
